// File: rtl/branch_predictor.sv
// PC-indexed table of 2-bit saturating counters with branch/mispredict
// performance counters; lookup is combinational, training lands on the next edge.
module branch_predictor #(
  parameter int unsigned IDX_BITS = 4,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      pc_IF,
  output logic             branch_predict_IF,
  input  logic [31:0]      pc_EX,
  input  logic             btype_EX,
  input  logic             stall_EX,
  input  logic             branch_predict_EX,
  input  logic             branch_result_EX,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispredict_cnt
);

  localparam int unsigned ENTRIES = 1 << IDX_BITS;

  logic [1:0]          table_q [ENTRIES];
  logic [1:0]          table_d [ENTRIES];
  logic [CNT_W-1:0]    branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0]    mispredict_cnt_q, mispredict_cnt_d;
  logic [IDX_BITS-1:0] idx_if, idx_ex;
  logic                upd;

  assign idx_if = pc_IF[IDX_BITS+1:2];
  assign idx_ex = pc_EX[IDX_BITS+1:2];
  assign upd    = btype_EX & ~stall_EX;

  // No bypass: IF always sees the registered entry, even when EX writes it.
  assign branch_predict_IF = table_q[idx_if][1];
  assign branch_cnt        = branch_cnt_q;
  assign mispredict_cnt    = mispredict_cnt_q;

  always_comb begin
    table_d = table_q;
    if (upd) begin
      if (branch_result_EX) begin
        if (table_q[idx_ex] != 2'b11) table_d[idx_ex] = table_q[idx_ex] + 2'b01;
      end else begin
        if (table_q[idx_ex] != 2'b00) table_d[idx_ex] = table_q[idx_ex] - 2'b01;
      end
    end
  end

  always_comb begin
    branch_cnt_d     = branch_cnt_q;
    mispredict_cnt_d = mispredict_cnt_q;
    if (upd) begin
      if (!(&branch_cnt_q)) branch_cnt_d = branch_cnt_q + 1'b1;
      if ((branch_predict_EX != branch_result_EX) && !(&mispredict_cnt_q))
        mispredict_cnt_d = mispredict_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < ENTRIES; i++) table_q[i] <= 2'b01;
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      table_q          <= table_d;
      branch_cnt_q     <= branch_cnt_d;
      mispredict_cnt_q <= mispredict_cnt_d;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: reset, training, same-cycle conflict,
// stall, aliasing, async reset and counter saturation (second instance, CNT_W=4).
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_IF, pc_EX;
  logic        btype_EX, stall_EX, branch_predict_EX, branch_result_EX;
  logic        pred;
  logic [15:0] bcnt, mcnt;
  logic        pred4;
  logic [3:0]  bcnt4, mcnt4;

  int unsigned total  = 0;
  int unsigned passed = 0;

  always #5 clk = ~clk;

  branch_predictor #(.IDX_BITS(4), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .pc_IF(pc_IF), .branch_predict_IF(pred),
    .pc_EX(pc_EX), .btype_EX(btype_EX), .stall_EX(stall_EX),
    .branch_predict_EX(branch_predict_EX), .branch_result_EX(branch_result_EX),
    .branch_cnt(bcnt), .mispredict_cnt(mcnt)
  );

  branch_predictor #(.IDX_BITS(4), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .pc_IF(pc_IF), .branch_predict_IF(pred4),
    .pc_EX(pc_EX), .btype_EX(btype_EX), .stall_EX(stall_EX),
    .branch_predict_EX(branch_predict_EX), .branch_result_EX(branch_result_EX),
    .branch_cnt(bcnt4), .mispredict_cnt(mcnt4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ex(input logic [31:0] pc, input logic bt, input logic st,
                    input logic pe, input logic res);
    pc_EX = pc; btype_EX = bt; stall_EX = st;
    branch_predict_EX = pe; branch_result_EX = res;
  endtask

  initial begin
    rst_n = 1'b1;
    pc_IF = '0;
    ex(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    #1;

    // 1: reset state
    chk("rst_bcnt", 32'(bcnt), 0);
    chk("rst_mcnt", 32'(mcnt), 0);
    for (int i = 0; i < 16; i++) begin
      pc_IF = 32'(i * 4);
      #1 chk($sformatf("rst_pred_%0d", i), 32'(pred), 0);
    end

    // 2: three taken branches at 0x40, predicted 0,1,1
    pc_IF = 32'h40;
    ex(32'h40, 1'b1, 1'b0, 1'b0, 1'b1);
    #1 chk("t2_pre", 32'(pred), 0);
    tick();
    chk("t2_e1", 32'(pred), 1);
    ex(32'h40, 1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    chk("t2_e2", 32'(pred), 1);
    tick();
    chk("t2_e3", 32'(pred), 1);
    ex(32'h40, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("t2_bcnt", 32'(bcnt), 3);
    chk("t2_mcnt", 32'(mcnt), 1);

    // 3: same index read and trained in one cycle
    pc_IF = 32'h44;
    ex(32'h44, 1'b1, 1'b0, 1'b0, 1'b1);
    #1 chk("t3_same", 32'(pred), 0);
    tick();
    ex(32'h44, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 chk("t3_next", 32'(pred), 1);
    chk("t3_bcnt", 32'(bcnt), 4);
    chk("t3_mcnt", 32'(mcnt), 2);

    // 4: stalled branch trains exactly once
    pc_IF = 32'h4C;
    ex(32'h4C, 1'b1, 1'b1, 1'b1, 1'b1);
    repeat (4) tick();
    chk("t4_stall_pred", 32'(pred), 0);
    chk("t4_stall_bcnt", 32'(bcnt), 4);
    stall_EX = 1'b0;
    tick();
    ex(32'h4C, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 chk("t4_rel_pred", 32'(pred), 1);
    chk("t4_rel_bcnt", 32'(bcnt), 5);
    chk("t4_rel_mcnt", 32'(mcnt), 2);
    // one not-taken step must fall back to 01 if only a single step happened
    ex(32'h4C, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    ex(32'h4C, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 chk("t4_single", 32'(pred), 0);
    chk("t4_nt_bcnt", 32'(bcnt), 6);
    chk("t4_nt_mcnt", 32'(mcnt), 3);
    pc_IF = 32'h50;
    ex(32'h50, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(); tick();
    chk("t4_nobt_pred", 32'(pred), 0);
    chk("t4_nobt_bcnt", 32'(bcnt), 6);

    // 5: aliasing 0x08 / 0x48
    ex(32'h08, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    branch_predict_EX = 1'b1;
    tick();
    ex(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    pc_IF = 32'h48;
    #1 chk("t5_alias", 32'(pred), 1);
    chk("t5_bcnt", 32'(bcnt), 8);
    chk("t5_mcnt", 32'(mcnt), 4);
    ex(32'h48, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    ex(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    pc_IF = 32'h08;
    #1 chk("t5_strong", 32'(pred), 1);
    chk("t5_mcnt2", 32'(mcnt), 5);

    // 6a: saturation of the narrow instance
    chk("t6_b4_pre", 32'(bcnt4), 9);
    chk("t6_m4_pre", 32'(mcnt4), 5);
    ex(32'h60, 1'b1, 1'b0, 1'b1, 1'b1);
    repeat (20) tick();
    chk("t6_b4_sat", 32'(bcnt4), 15);
    chk("t6_m4", 32'(mcnt4), 5);
    chk("t6_bcnt", 32'(bcnt), 29);
    pc_IF = 32'h60;
    #1 chk("t6_p4", 32'(pred4), 1);

    // 6b: asynchronous reset between edges, mid-training
    ex(32'h40, 1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("t6_async_pred", 32'(pred), 0);
    chk("t6_async_bcnt", 32'(bcnt), 0);
    chk("t6_async_mcnt", 32'(mcnt), 0);
    chk("t6_async_b4", 32'(bcnt4), 0);
    ex(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      pc_IF = 32'(32'h100 + i * 4);
      #1 chk($sformatf("t6_post_pred_%0d", i), 32'(pred), 0);
    end
    tick();
    chk("t6_post_bcnt", 32'(bcnt), 0);
    chk("t6_post_mcnt", 32'(mcnt), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Dynamic branch predictor for the 5-stage RISC-V pipeline; it generates the prediction that the EX-stage flush logic later checks. In IF it looks up a PC-indexed table of 2-bit saturating counters and drives `branch_predict_IF`, which the pipeline registers carry forward to EX as `branch_predict_EX`. When a conditional branch resolves in EX, the block trains the matching counter. It also keeps branch and misprediction performance counters.

## Interface
Parameters:
- `IDX_BITS`, default 4: table index width. The table has 2^IDX_BITS entries.
- `CNT_W`, default 16: width of each performance counter.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `pc_IF`, input, 32: PC of the instruction being fetched.
- `branch_predict_IF`, output, 1: prediction for `pc_IF`. 1 = taken.
- `pc_EX`, input, 32: PC of the instruction in EX.
- `btype_EX`, input, 1: the EX instruction is a conditional branch.
- `stall_EX`, input, 1: EX is held this cycle. No training occurs.
- `branch_predict_EX`, input, 1: the prediction that was made for the EX instruction.
- `branch_result_EX`, input, 1: actual branch outcome. 1 = taken.
- `branch_cnt`, output, CNT_W: number of resolved conditional branches.
- `mispredict_cnt`, output, CNT_W: number of resolved branches where the prediction differed from the outcome.

## Operation
Table:
- 2^IDX_BITS entries of 2-bit counters.
- Counter encoding: 00 = strong not-taken, 01 = weak not-taken, 10 = weak taken, 11 = strong taken.
- Index: `pc[IDX_BITS+1:2]`, used for both lookup and update. PC bits [1:0] are ignored.

Lookup:
- `branch_predict_IF` = bit 1 of `table[idx(pc_IF)]`.
- Purely combinational from current register state.

Update:
- Occurs when `btype_EX & ~stall_EX`. Call this condition `upd`.
- If `branch_result_EX` = 1: the counter at `idx(pc_EX)` increments, saturating at 11.
- If `branch_result_EX` = 0: the counter decrements, saturating at 00.
- Only that one entry changes. If `upd` = 0, the table is unchanged.
- `jtype` instructions never train the table.

Performance counters:
- On `upd`: `branch_cnt` increments.
- On `upd` with `branch_predict_EX != branch_result_EX`: `mispredict_cnt` also increments.
- Both counters saturate at all-ones and do not wrap.
- `mispredict_cnt` never exceeds `branch_cnt`.

Reset:
- `rst_n` low forces, immediately and asynchronously, every table entry to 01 and both performance counters to 0.
- As a result, `branch_predict_IF` reads 0 during and after reset.
- Reset asserted mid-operation discards all training.

## Timing
- Lookup latency: 0 cycles. The prediction is valid in the same cycle as `pc_IF`.
- Update latency: 1 cycle. The counter changes at the rising edge that ends the `upd` cycle.
- Same index read and written in one cycle: no bypass. IF sees the pre-update value. The updated value is visible from the next cycle.
- Performance counters update on the same edge as the table. Outputs are taken directly from registers.
- `stall_EX` held for N cycles with a branch in EX: the entry is trained exactly once, on the first unstalled cycle.
- Aliasing: PCs whose index bits are equal share an entry. No tag check is performed.

## Test plan
1. Reset, then sweep `pc_IF` over all 16 indices. Required: `branch_predict_IF` = 0 everywhere; both performance counters = 0.
2. Resolve 3 taken branches at `pc_EX` = 0x40 with `branch_predict_EX` = 0, 1, 1. Required: entry 0 goes 01→10→11→11; `branch_predict_IF`(0x40) = 1 after the first edge; `branch_cnt` = 3; `mispredict_cnt` = 1.
3. Same-cycle conflict: `pc_IF` = `pc_EX` = 0x44, entry at 01, taken update. Required: prediction reads 0 that cycle and 1 the next cycle.
4. `btype_EX` = 1 with `stall_EX` = 1 held for 4 cycles, then released. Required: a single counter step and `branch_cnt` + 1. Repeating with `btype_EX` = 0 and a taken result produces no change.
5. Aliasing: train 0x08 strongly taken. Required: `pc_IF` = 0x48 predicts taken with `IDX_BITS` = 4.
6. Assert `rst_n` low asynchronously mid-training, between clock edges. Required: all entries return to 01 and the counters return to 0 without waiting for a clock edge. With `CNT_W` = 4 and 20 updates, `branch_cnt` holds at 15.
